axi_sram_responder: RTL and testbench

// - AXI4 slave endpoint (responder side of the SoC AXI node) backing a MEM_WORDS x AXI_DATA_WIDTH scratch SRAM.
// - Serves INCR bursts, one transaction at a time. Sits on a spare node master port as a scratch / DMA target.

---
 rtl/axi_sram_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_responder.sv
// AXI4 slave endpoint backing a MEM_WORDS x AXI_DATA_WIDTH scratch SRAM; INCR bursts, one transaction at a time.
// Latency: first R beat the cycle after the AR handshake, then up to one beat per cycle; B the cycle after the last W beat.
// Backpressure: R payload and B are held while *_ready is low; AW/AR accepted only when idle; W always ready in a write burst.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   aw_* / w_* / b_*      write address, write data and write response channels
//   ar_* / r_*            read address and read data channels
// Optional feature: define AXI_SRAM_RANGE_CHECK_EN to give beats past the end of the SRAM a SLVERR response
// (writes suppressed, reads return 0) instead of wrapping the word index.
module axi_sram_responder #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int MEM_WORDS      = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]                  aw_len,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   output logic [1:0]                  b_resp,
   output logic                        b_valid,
   input  logic                        b_ready,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]                  ar_len,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   output logic [AXI_ID_WIDTH-1:0]     r_id,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   output logic                        r_valid,
   input  logic                        r_ready
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int LSB_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_WORDS);
   // Word address keeps every address bit above the byte lane plus one carry bit,
   // so a burst running off the end of the SRAM is still visible to the range check.
   localparam int WA_W   = AXI_ADDR_WIDTH - LSB_W + 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WDATA,
      S_BRESP,
      S_RDATA
   } state_t;

   state_t state_q, state_d;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [WA_W-1:0]           word_q;     // word address of the next beat to write / fetch
   logic [7:0]                beat_q;     // index of the current beat within the burst
   logic [7:0]                len_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic                      err_q;      // sticky write-burst error
   logic                      rr_rd_q;    // 1: read wins the next AW/AR contention
   logic                      r_valid_q;
   logic                      r_last_q;
   logic [1:0]                r_resp_q;
   logic [AXI_DATA_WIDTH-1:0] r_data_q;

   logic                      grant_w, grant_r;
   logic                      w_hs, r_hs, w_final;
   logic [WA_W-1:0]           aw_word, ar_word, rd_word;
   logic                      wr_oor, rd_oor;
   logic [AXI_DATA_WIDTH-1:0] fetch_data;
   logic [1:0]                fetch_resp;

   assign aw_word = {1'b0, aw_addr[AXI_ADDR_WIDTH-1:LSB_W]};
   assign ar_word = {1'b0, ar_addr[AXI_ADDR_WIDTH-1:LSB_W]};

   // The read port looks at the incoming AR address while idle so the first beat
   // is registered on the AR handshake edge; afterwards it follows the burst counter.
   assign rd_word = (state_q == S_IDLE) ? ar_word : word_q;

`ifdef AXI_SRAM_RANGE_CHECK_EN
   assign wr_oor = |word_q[WA_W-1:IDX_W];
   assign rd_oor = |rd_word[WA_W-1:IDX_W];
`else
   assign wr_oor = 1'b0;
   assign rd_oor = 1'b0;
`endif

   assign fetch_data = rd_oor ? '0 : mem[rd_word[IDX_W-1:0]];
   assign fetch_resp = rd_oor ? RESP_SLVERR : RESP_OKAY;

   // Address bits below the data width and the word bits above the SRAM depth
   // only matter when the range check is built in.
   logic unused_bits;
   assign unused_bits = ^{aw_addr[LSB_W-1:0], ar_addr[LSB_W-1:0],
                          word_q[WA_W-1:IDX_W], rd_word[WA_W-1:IDX_W]};

   // Round-robin grant between the address channels, only in IDLE.
   always_comb begin
      grant_w = 1'b0;
      grant_r = 1'b0;
      if (state_q == S_IDLE) begin
         if (aw_valid && ar_valid) begin
            grant_r = rr_rd_q;
            grant_w = !rr_rd_q;
         end else begin
            grant_w = aw_valid;
            grant_r = ar_valid;
         end
      end
   end

   assign w_hs    = (state_q == S_WDATA) && w_valid;
   assign w_final = w_hs && (beat_q == len_q);
   assign r_hs    = r_valid_q && r_ready;

   // FSM next state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      aw_ready = 1'b0;
      ar_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            aw_ready = grant_w;
            ar_ready = grant_r;
            if (grant_w)      state_d = S_WDATA;
            else if (grant_r) state_d = S_RDATA;
         end
         S_WDATA: begin
            w_ready = 1'b1;
            if (w_final) state_d = S_BRESP;
         end
         S_BRESP: begin
            b_valid = 1'b1;
            if (b_ready) state_d = S_IDLE;
         end
         S_RDATA: begin
            if (r_hs && r_last_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // SRAM array: byte-lane writes, never reset.
   always_ff @(posedge clk) begin
      if (w_hs && !wr_oor) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) mem[word_q[IDX_W-1:0]][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   // Burst bookkeeping and registered read channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q    <= '0;
         beat_q    <= '0;
         len_q     <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         rr_rd_q   <= 1'b0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         r_resp_q  <= RESP_OKAY;
         r_data_q  <= '0;
      end else begin
         if (grant_w) begin
            word_q  <= aw_word;
            beat_q  <= '0;
            len_q   <= aw_len;
            id_q    <= aw_id;
            err_q   <= 1'b0;
            rr_rd_q <= 1'b1;
         end

         // The burst length comes from aw_len alone; a disagreeing w_last only flags the response.
         if (w_hs) begin
            word_q <= word_q + WA_W'(1);
            beat_q <= beat_q + 8'd1;
            if ((w_last != (beat_q == len_q)) || wr_oor) err_q <= 1'b1;
         end

         if (grant_r) begin
            word_q    <= ar_word + WA_W'(1);
            beat_q    <= '0;
            len_q     <= ar_len;
            id_q      <= ar_id;
            rr_rd_q   <= 1'b0;
            r_valid_q <= 1'b1;
            r_last_q  <= (ar_len == 8'd0);
            r_resp_q  <= fetch_resp;
            r_data_q  <= fetch_data;
         end else if (r_hs) begin
            if (r_last_q) begin
               r_valid_q <= 1'b0;
               r_last_q  <= 1'b0;
            end else begin
               word_q   <= word_q + WA_W'(1);
               beat_q   <= beat_q + 8'd1;
               r_last_q <= ((beat_q + 8'd1) == len_q);
               r_resp_q <= fetch_resp;
               r_data_q <= fetch_data;
            end
         end
      end
   end

   assign b_id    = id_q;
   assign b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
   assign r_id    = id_q;
   assign r_data  = r_data_q;
   assign r_resp  = r_resp_q;
   assign r_last  = r_last_q;
   assign r_valid = r_valid_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: stimulus pushes expected B/R responses
// computed from a byte-level memory model; a negedge monitor pops and compares them.
// Also checks reset values, arbitration order, read/B timing and R hold under stall.
module tb_axi_sram_responder;

   localparam int IW = 4;
   localparam int DW = 32;
   localparam int MW = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] aw_id, ar_id, b_id, r_id;
   logic [31:0]   aw_addr, ar_addr;
   logic [7:0]    aw_len, ar_len;
   logic          aw_valid, aw_ready, ar_valid, ar_ready;
   logic [DW-1:0] w_data, r_data;
   logic [3:0]    w_strb;
   logic          w_last, w_valid, w_ready;
   logic [1:0]    b_resp, r_resp;
   logic          b_valid, b_ready, r_last, r_valid, r_ready;

   always #5 clk = ~clk;

   axi_sram_responder #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MEM_WORDS(MW)
   ) dut (
      .clk(clk), .rst(rst),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
   );

   typedef struct packed {
      logic [IW-1:0] id;
      logic [1:0]    resp;
   } b_exp_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } r_exp_t;

   b_exp_t        bq[$];
   r_exp_t        rq[$];
   logic [DW-1:0] mdl [MW];
   logic [DW-1:0] wd [256];
   logic [3:0]    ws [256];
   int            n_tests = 0;
   int            n_fail  = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Beat k of a burst starting at byte address 'start' sits at byte address start + 4k.
   function automatic bit beat_oor(input logic [31:0] start, input int k);
      longint unsigned ba;
      ba = {32'd0, start} + longint'(4 * k);
`ifdef AXI_SRAM_RANGE_CHECK_EN
      return ba >= longint'(MW * 4);
`else
      return (ba == 64'hFFFF_FFFF_FFFF_FFFF);
`endif
   endfunction

   function automatic int beat_idx(input logic [31:0] start, input int k);
      longint unsigned ba;
      ba = {32'd0, start} + longint'(4 * k);
      return int'((ba / 4) % MW);
   endfunction

   // ---------------- monitor ----------------
   logic   stall_p = 1'b0;
   logic [38:0] held;
   b_exp_t be;
   r_exp_t re;

   always @(negedge clk) begin
      if (rst) begin
         stall_p = 1'b0;
      end else begin
         if (stall_p) check("r_hold", {r_valid, r_id, r_data, r_resp, r_last}, {1'b1, held});
         stall_p = r_valid && !r_ready;
         held    = {r_id, r_data, r_resp, r_last};
         if (b_valid && b_ready) begin
            if (bq.size() == 0) check("b_unexpected", b_valid, 0);
            else begin
               be = bq.pop_front();
               check("b_id", b_id, be.id);
               check("b_resp", b_resp, be.resp);
            end
         end
         if (r_valid && r_ready) begin
            if (rq.size() == 0) check("r_unexpected", r_valid, 0);
            else begin
               re = rq.pop_front();
               check("r_id", r_id, re.id);
               check("r_data", r_data, re.data);
               check("r_resp", r_resp, re.resp);
               check("r_last", r_last, re.last);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic addr_phase(input bit is_w, input bit contend, output bit ok);
      int cyc;
      cyc = 0;
      ok  = 1'b0;
      aw_valid = is_w | contend;
      ar_valid = !is_w | contend;
      @(negedge clk);
      if (contend) begin
         if (is_w) check("arb_aw_first", {aw_ready, ar_ready}, 2'b10);
         else      check("arb_ar_next", {aw_ready, ar_ready}, 2'b01);
      end
      while (cyc < 20) begin
         if (is_w ? aw_ready : ar_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      if (is_w) check("aw_handshake", aw_ready, 1);
      else      check("ar_handshake", ar_ready, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      ar_valid = 1'b0;
   endtask

   task automatic write_beat(input logic [31:0] addr, input int k, input int len, input int bad_last);
      w_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
         @(posedge clk); #1;
      end
      w_data  = wd[k];
      w_strb  = ws[k];
      w_last  = (k == len) ^ (k == bad_last);
      w_valid = 1'b1;
      @(negedge clk);
      check("w_ready", w_ready, 1);
      @(posedge clk); #1;
      w_valid = 1'b0;
      w_last  = 1'b0;
      if (!beat_oor(addr, k))
         for (int j = 0; j < 4; j++)
            if (ws[k][j]) mdl[beat_idx(addr, k)][8*j +: 8] = wd[k][8*j +: 8];
   endtask

   task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                           input int bad_last, input bit contend);
      bit err;
      bit ok;
      int cyc;
      err = 1'b0;
      for (int k = 0; k <= len; k++)
         if (beat_oor(addr, k) || k == bad_last) err = 1'b1;
      bq.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
      aw_id = id; aw_addr = addr; aw_len = 8'(len);
      ar_id = ~id; ar_addr = addr; ar_len = 8'd0;
      addr_phase(1'b1, contend, ok);
      if (!ok) return;
      for (int k = 0; k <= len; k++) write_beat(addr, k, len, bad_last);
      @(negedge clk);
      check("b_valid_rise", b_valid, 1);
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      b_ready = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!b_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("b_handshake", b_valid, 1);
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   // mode 0: r_ready always high, 1: toggles 1010..., 2: random
   task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                          input int mode, input bit contend);
      bit     ok, done;
      int     cyc;
      r_exp_t e, first;
      for (int k = 0; k <= len; k++) begin
         e.id   = id;
         e.resp = beat_oor(addr, k) ? 2'b10 : 2'b00;
         e.data = beat_oor(addr, k) ? '0 : mdl[beat_idx(addr, k)];
         e.last = (k == len);
         if (k == 0) first = e;
         rq.push_back(e);
      end
      ar_id = id; ar_addr = addr; ar_len = 8'(len);
      aw_id = ~id; aw_addr = addr; aw_len = 8'd0;
      r_ready = 1'b0;
      addr_phase(1'b0, contend, ok);
      if (!ok) return;
      @(negedge clk);
      check("r_latency", r_valid, 1);
      check("r_first_data", r_data, first.data);
      check("r_first_last", r_last, first.last);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         @(posedge clk); #1;
         case (mode)
            0:       r_ready = 1'b1;
            1:       r_ready = (cyc % 2 == 0);
            default: r_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (r_valid && r_ready && r_last) done = 1'b1;
         cyc++;
      end
      check("r_done", done, 1);
      @(posedge clk); #1;
      r_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d checks expected completion", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          len, bl;
      bit          ok;

      rst = 1'b1;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0;
      w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
      b_ready = 1'b0; r_ready = 1'b0;
      for (int i = 0; i < MW; i++) mdl[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {aw_ready, ar_ready, w_ready, b_valid, r_valid, b_resp, r_resp,
                            r_last, r_data, b_id, r_id}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single write / read with simultaneous AW+AR: write first, then read.
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(4'h3, 32'h10, 0, -1, 1'b1);
      do_read(4'h5, 32'h10, 0, 0, 1'b1);

      // Fill the whole SRAM so every later read has known contents.
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 256; k++) begin
            wd[k] = $urandom;
            ws[k] = 4'hF;
         end
         do_write(4'(b), 32'(b * 1024), 255, -1, 1'b0);
      end

      // 4-beat burst, read back with toggling r_ready.
      for (int k = 0; k < 4; k++) begin
         wd[k] = 32'(k + 1);
         ws[k] = 4'hF;
      end
      do_write(4'h1, 32'h100, 3, -1, 1'b0);
      do_read(4'h2, 32'h100, 3, 1, 1'b0);

      // Byte strobes.
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
      do_write(4'h4, 32'h200, 0, -1, 1'b0);
      wd[0] = 32'h0000_0000; ws[0] = 4'h5;
      do_write(4'h4, 32'h200, 0, -1, 1'b0);
      do_read(4'h6, 32'h200, 0, 0, 1'b0);

      // len 1 burst with w_last on the first beat: SLVERR, both beats still written.
      wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(4'h7, 32'h300, 1, 0, 1'b0);
      do_read(4'h8, 32'h300, 1, 2, 1'b0);

      // Burst running past the top of the SRAM.
      wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(4'h9, 32'hFFC, 1, -1, 1'b0);
      do_read(4'h9, 32'hFFC, 1, 0, 1'b0);
      do_read(4'hA, 32'h0, 0, 0, 1'b0);

      // Reset in the middle of a write burst: no B, committed beats stay.
      aw_id = 4'hC; aw_addr = 32'h400; aw_len = 8'd3;
      addr_phase(1'b1, 1'b0, ok);
      for (int k = 0; k < 2; k++) begin
         wd[k] = $urandom;
         ws[k] = 4'hF;
         write_beat(32'h400, k, 3, -1);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midburst_rst_outputs", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_read(4'hD, 32'h400, 3, 0, 1'b0);

      // Randomised traffic.
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k <= len; k++) begin
               wd[k] = $urandom;
               ws[k] = 4'($urandom_range(0, 15));
            end
            bl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            do_write(4'($urandom), a, len, bl, 1'b0);
         end else begin
            do_read(4'($urandom), a, len, $urandom_range(0, 2), 1'b0);
         end
      end

      repeat (3) @(posedge clk);
      check("b_queue_drained", bq.size(), 0);
      check("r_queue_drained", rq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
